// File: rtl/int_sched_if.sv
// Bundle between the interrupt scheduler, the pipeline and the CP0 register block.
// The master side drives requests/status/pipeline handshake; the slave side is the scheduler.
interface int_sched_if #(
    parameter int NSRC = 3
);
    logic [NSRC-1:0] irq;
    logic [31:0]     sta;
    logic            pipe_ready;
    logic            eret;
    logic            int_req;
    logic            inta;
    logic [31:0]     cause;
    logic [31:0]     vector;
    logic [NSRC-1:0] pending;
    logic [3:0]      depth;
    logic            err;

    modport master (
        output irq, sta, pipe_ready, eret,
        input  int_req, inta, cause, vector, pending, depth, err
    );

    modport slave (
        input  irq, sta, pipe_ready, eret,
        output int_req, inta, cause, vector, pending, depth, err
    );
endinterface

// File: rtl/int_sched.sv
// Nested-interrupt scheduler: latches request edges, picks the highest-priority eligible
// source, handshakes with the pipeline and tracks in-service nesting for eret unwinding.
module int_sched #(
    parameter int          NSRC       = 3,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0080
) (
    input logic       clk,
    input logic       rst_n,
    int_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t          state, state_nx;
    logic [NSRC-1:0] irq_q, pending_q, rise, elig, ack_mask;
    logic [3:0]      stack_q [DEPTH];
    logic [3:0]      depth_q, cur, sel, src_q;
    logic            any_elig, err_q, int_req, inta;
    logic [31:0]     cause_q, vector_q;
    logic            unused_sta;

    assign rise       = bus.irq & ~irq_q;
    assign unused_sta = ^bus.sta[31:NSRC+1];

    // Current service level is the stack top; NSRC means nothing is in service.
    always_comb begin
        cur = 4'(NSRC);
        for (int k = 0; k < DEPTH; k++) begin
            if (depth_q == 4'(k + 1)) cur = stack_q[k];
        end
    end

    always_comb begin
        elig     = '0;
        sel      = '0;
        ack_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            elig[i]     = pending_q[i] & bus.sta[0] & bus.sta[i+1] &
                          (4'(i) < cur) & (depth_q < 4'(DEPTH));
            ack_mask[i] = (state == ACK) && (src_q == 4'(i));
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) sel = 4'(i);
        end
        any_elig = |elig;
    end

    always_comb begin
        state_nx = state;
        int_req  = 1'b0;
        inta     = 1'b0;
        case (state)
            IDLE: if (any_elig) state_nx = REQ;
            REQ: begin
                int_req = 1'b1;
                if (!any_elig)          state_nx = IDLE;
                else if (bus.pipe_ready) state_nx = ACK;
            end
            ACK: begin
                inta     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            src_q     <= '0;
            cause_q   <= '0;
            vector_q  <= '0;
        end else begin
            state     <= state_nx;
            irq_q     <= bus.irq;
            pending_q <= (pending_q & ~ack_mask) | rise;
            if ((state == IDLE || state == REQ) && any_elig) src_q <= sel;
            // Cause/vector are loaded on entry to ACK so they are stable while inta is high.
            if (state == REQ && any_elig && bus.pipe_ready) begin
                cause_q  <= {28'd0, sel} + 32'd1;
                vector_q <= VEC_BASE + {28'd0, sel} * VEC_STRIDE;
            end
        end
    end

    // An eret colliding with ACK is dropped so the push always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) stack_q[k] <= '0;
        end else begin
            if (bus.eret && (state == ACK || depth_q == 4'd0)) err_q <= 1'b1;
            if (state == ACK) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (depth_q == 4'(k)) stack_q[k] <= src_q;
                end
                depth_q <= depth_q + 4'd1;
            end else if (bus.eret && depth_q != 4'd0) begin
                depth_q <= depth_q - 4'd1;
            end
        end
    end

    assign bus.int_req = int_req;
    assign bus.inta    = inta;
    assign bus.cause   = cause_q;
    assign bus.vector  = vector_q;
    assign bus.pending = pending_q;
    assign bus.depth   = depth_q;
    assign bus.err     = err_q;
endmodule
